// File: rtl/usb_txn_engine_if.sv
// Request, completion, packet-encoder and packet-decoder signals of usb_txn_engine.
// The slave modport is the engine's view; master is the host/PHY side.
interface usb_txn_engine_if #(
   parameter int DATA_BYTES = 8
);
   logic                    req_valid;
   logic                    req_ready;
   logic                    req_is_in;
   logic [3:0]              req_endp;
   logic [8*DATA_BYTES-1:0] req_data;
   logic                    done;
   logic                    success;
   logic [8*DATA_BYTES-1:0] rsp_data;
   logic                    tx_valid;
   logic                    tx_ready;
   logic [3:0]              tx_pid;
   logic [6:0]              tx_addr;
   logic [3:0]              tx_endp;
   logic [8*DATA_BYTES-1:0] tx_data;
   logic                    rx_valid;
   logic [3:0]              rx_pid;
   logic [8*DATA_BYTES-1:0] rx_data;
   logic                    rx_err;
   logic [15:0]             stat_retries;

   modport slave (
      input  req_valid, req_is_in, req_endp, req_data,
      input  tx_ready, rx_valid, rx_pid, rx_data, rx_err,
      output req_ready, done, success, rsp_data,
      output tx_valid, tx_pid, tx_addr, tx_endp, tx_data,
      output stat_retries
   );

   modport master (
      output req_valid, req_is_in, req_endp, req_data,
      output tx_ready, rx_valid, rx_pid, rx_data, rx_err,
      input  req_ready, done, success, rsp_data,
      input  tx_valid, tx_pid, tx_addr, tx_endp, tx_data,
      input  stat_retries
   );
endinterface

// File: rtl/usb_txn_engine.sv
// USB host transaction engine: token/data/handshake sequencing with retries.
// Define USB_TXN_STATS_EN to build the saturating stat_retries counter.
module usb_txn_engine #(
   parameter int         DATA_BYTES  = 8,
   parameter logic [6:0] DEV_ADDR    = 7'h05,
   parameter int         TIMEOUT_CYC = 255,
   parameter int         MAX_RETRY   = 8
) (
   input logic              clk,
   input logic              rst_L,
   usb_txn_engine_if.slave  bus
);
   localparam int DW = 8*DATA_BYTES;
   localparam logic [3:0] PID_OUT = 4'b0001;
   localparam logic [3:0] PID_IN  = 4'b1001;
   localparam logic [3:0] PID_D0  = 4'b0011;
   localparam logic [3:0] PID_D1  = 4'b1011;
   localparam logic [3:0] PID_ACK = 4'b0010;
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);
   localparam logic [7:0]  ATT_LIM  = 8'(MAX_RETRY);

   typedef enum logic [2:0] {
      IDLE, TOKEN, DATA, WAIT_HS, WAIT_DATA, ACK, FIN
   } state_t;

   state_t          state_q, state_d;
   logic            is_in_q, is_in_d;
   logic [3:0]      endp_q, endp_d;
   logic [DW-1:0]   data_q, data_d;
   logic            out_tog_q, out_tog_d;
   logic            in_tog_q, in_tog_d;
   logic            dup_q, dup_d;
   logic [7:0]      att_q, att_d;
   logic [15:0]     tmo_q, tmo_d;
   logic            tx_valid_q, tx_valid_d;
   logic [3:0]      tx_pid_q, tx_pid_d;
   logic [DW-1:0]   tx_data_q, tx_data_d;
   logic            done_q, done_d;
   logic            success_q, success_d;
   logic [DW-1:0]   rsp_q, rsp_d;
   logic            fail;
   logic            tmo_hit;
   logic            rx_is_data;

   assign tmo_hit    = (tmo_q == TMO_LAST);
   assign rx_is_data = (bus.rx_pid == PID_D0) || (bus.rx_pid == PID_D1);

   always_comb begin
      state_d    = state_q;
      is_in_d    = is_in_q;
      endp_d     = endp_q;
      data_d     = data_q;
      out_tog_d  = out_tog_q;
      in_tog_d   = in_tog_q;
      dup_d      = dup_q;
      att_d      = att_q;
      tmo_d      = tmo_q;
      tx_valid_d = tx_valid_q;
      tx_pid_d   = tx_pid_q;
      tx_data_d  = tx_data_q;
      done_d     = 1'b0;
      success_d  = success_q;
      rsp_d      = rsp_q;
      fail       = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               is_in_d    = bus.req_is_in;
               endp_d     = bus.req_endp;
               data_d     = bus.req_data;
               att_d      = 8'd0;
               state_d    = TOKEN;
               tx_valid_d = 1'b1;
               tx_pid_d   = bus.req_is_in ? PID_IN : PID_OUT;
            end
         end
         TOKEN: begin
            if (bus.tx_ready) begin
               if (is_in_q) begin
                  state_d    = WAIT_DATA;
                  tx_valid_d = 1'b0;
                  tmo_d      = 16'd0;
               end else begin
                  state_d   = DATA;
                  tx_pid_d  = out_tog_q ? PID_D1 : PID_D0;
                  tx_data_d = data_q;
               end
            end
         end
         DATA: begin
            if (bus.tx_ready) begin
               state_d    = WAIT_HS;
               tx_valid_d = 1'b0;
               tmo_d      = 16'd0;
            end
         end
         WAIT_HS: begin
            if (bus.rx_valid) begin
               if (bus.rx_pid == PID_ACK && !bus.rx_err) begin
                  out_tog_d = ~out_tog_q;
                  state_d   = FIN;
                  done_d    = 1'b1;
                  success_d = 1'b1;
               end else begin
                  fail = 1'b1;
               end
            end else if (tmo_hit) begin
               fail = 1'b1;
            end else begin
               tmo_d = tmo_q + 16'd1;
            end
         end
         WAIT_DATA: begin
            if (bus.rx_valid) begin
               if (rx_is_data && !bus.rx_err) begin
                  // A duplicate is still ACKed so the device advances.
                  state_d    = ACK;
                  tx_valid_d = 1'b1;
                  tx_pid_d   = PID_ACK;
                  dup_d      = (bus.rx_pid[3] != in_tog_q);
                  if (bus.rx_pid[3] == in_tog_q) begin
                     rsp_d    = bus.rx_data;
                     in_tog_d = ~in_tog_q;
                  end
               end else begin
                  fail = 1'b1;
               end
            end else if (tmo_hit) begin
               fail = 1'b1;
            end else begin
               tmo_d = tmo_q + 16'd1;
            end
         end
         ACK: begin
            if (bus.tx_ready) begin
               tx_valid_d = 1'b0;
               if (dup_q) begin
                  fail = 1'b1;
               end else begin
                  state_d   = FIN;
                  done_d    = 1'b1;
                  success_d = 1'b1;
               end
            end
         end
         FIN: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (fail) begin
         att_d = att_q + 8'd1;
         if (att_d == ATT_LIM) begin
            state_d    = FIN;
            tx_valid_d = 1'b0;
            done_d     = 1'b1;
            success_d  = 1'b0;
         end else begin
            state_d    = TOKEN;
            tx_valid_d = 1'b1;
            tx_pid_d   = is_in_q ? PID_IN : PID_OUT;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_L) begin
      if (!rst_L) begin
         state_q    <= IDLE;
         is_in_q    <= 1'b0;
         endp_q     <= 4'd0;
         data_q     <= '0;
         out_tog_q  <= 1'b0;
         in_tog_q   <= 1'b0;
         dup_q      <= 1'b0;
         att_q      <= 8'd0;
         tmo_q      <= 16'd0;
         tx_valid_q <= 1'b0;
         tx_pid_q   <= 4'd0;
         tx_data_q  <= '0;
         done_q     <= 1'b0;
         success_q  <= 1'b0;
         rsp_q      <= '0;
      end else begin
         state_q    <= state_d;
         is_in_q    <= is_in_d;
         endp_q     <= endp_d;
         data_q     <= data_d;
         out_tog_q  <= out_tog_d;
         in_tog_q   <= in_tog_d;
         dup_q      <= dup_d;
         att_q      <= att_d;
         tmo_q      <= tmo_d;
         tx_valid_q <= tx_valid_d;
         tx_pid_q   <= tx_pid_d;
         tx_data_q  <= tx_data_d;
         done_q     <= done_d;
         success_q  <= success_d;
         rsp_q      <= rsp_d;
      end
   end

   assign bus.req_ready = (state_q == IDLE);
   assign bus.done      = done_q;
   assign bus.success   = success_q;
   assign bus.rsp_data  = rsp_q;
   assign bus.tx_valid  = tx_valid_q;
   assign bus.tx_pid    = tx_pid_q;
   assign bus.tx_addr   = DEV_ADDR;
   assign bus.tx_endp   = endp_q;
   assign bus.tx_data   = tx_data_q;

`ifdef USB_TXN_STATS_EN
   logic [15:0] stat_q, stat_d;
   logic        retry;

   // Re-entering TOKEN from anywhere but IDLE is a retried attempt.
   assign retry = (state_d == TOKEN) && (state_q != IDLE) && (state_q != TOKEN);

   always_comb begin
      stat_d = stat_q;
      if (retry && stat_q != 16'hFFFF) stat_d = stat_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_L) begin
      if (!rst_L) stat_q <= 16'd0;
      else        stat_q <= stat_d;
   end

   assign bus.stat_retries = stat_q;
`else
   assign bus.stat_retries = 16'h0000;
`endif
endmodule

// File: tb/tb_usb_txn_engine.sv
// Randomized bench for usb_txn_engine with a transaction-level reference
// model of the expected packet stream, outcome and retry statistics.
module tb_usb_txn_engine;
   localparam int DB = 8;
   localparam int T  = 16;
   localparam int MR = 3;
   localparam logic [6:0] ADDR  = 7'h05;
   localparam logic [3:0] P_OUT = 4'h1;
   localparam logic [3:0] P_IN  = 4'h9;
   localparam logic [3:0] P_D0  = 4'h3;
   localparam logic [3:0] P_D1  = 4'hB;
   localparam logic [3:0] P_ACK = 4'h2;
   localparam logic [3:0] P_NAK = 4'hA;
   localparam logic [3:0] P_BAD = 4'hE;
`ifdef USB_TXN_STATS_EN
   localparam int STAT043 = 2;
`else
   localparam int STAT043 = 0;
`endif

   typedef enum int {K_ACK, K_NAK, K_BAD, K_NONE, K_D0, K_D1} kind_e;
   typedef struct packed {
      logic [3:0]  pid;
      logic [3:0]  endp;
      logic [63:0] data;
      logic        has_data;
   } pkt_t;

   logic clk = 1'b0;
   logic rst_L = 1'b0;

   usb_txn_engine_if #(.DATA_BYTES(DB)) bus();

   usb_txn_engine #(
      .DATA_BYTES(DB), .DEV_ADDR(ADDR),
      .TIMEOUT_CYC(T), .MAX_RETRY(MR)
   ) dut (
      .clk(clk), .rst_L(rst_L), .bus(bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   kind_e rk[MR];
   bit re[MR];
   int rd[MR];
   logic [63:0] rp[MR];
   pkt_t exp_q[$];
   bit exp_ok;
   logic [63:0] exp_rsp;
   bit m_out, m_in;
   int m_stat;
   logic [31:0] sig;
   bit last_ok;
   logic [63:0] last_rsp;

   task automatic chk(string nm, logic [63:0] act, logic [63:0] ex);
      total++;
      if (act !== ex) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, ex);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] pid_of(kind_e k);
      case (k)
         K_ACK:   return P_ACK;
         K_NAK:   return P_NAK;
         K_D0:    return P_D0;
         K_D1:    return P_D1;
         default: return P_BAD;
      endcase
   endfunction

   function automatic logic [15:0] exp_stat();
`ifdef USB_TXN_STATS_EN
      return 16'(m_stat);
`else
      return 16'h0000;
`endif
   endfunction

   // Builds the packet list and outcome from the response script rk/re/rp.
   task automatic model(bit is_in, logic [3:0] endp, logic [63:0] data);
      int a = 0;
      bit ok = 0;
      bit fin = 0;
      exp_q.delete();
      while (!fin) begin
         exp_q.push_back({(is_in ? P_IN : P_OUT), endp, 64'h0, 1'b0});
         if (!is_in) begin
            exp_q.push_back({(m_out ? P_D1 : P_D0), endp, data, 1'b1});
            if (rk[a] == K_ACK && !re[a]) begin
               ok = 1;
               m_out = !m_out;
            end
         end else if (!re[a] && (rk[a] == K_D0 || rk[a] == K_D1)) begin
            exp_q.push_back({P_ACK, endp, 64'h0, 1'b0});
            if ((rk[a] == K_D1) == m_in) begin
               ok = 1;
               exp_rsp = rp[a];
               m_in = !m_in;
            end
         end
         a++;
         if (ok || a == MR) fin = 1;
         else if (m_stat < 65535) m_stat++;
      end
      exp_ok = ok;
   endtask

   task automatic respond(int a);
      int w;
      if (a >= MR) begin
         total++;
         bad++;
         $display("FAIL attempts: got %0d want at most %0d", a + 1, MR);
         return;
      end
      if (rk[a] == K_NONE) begin
         w = 0;
         while (!(bus.tx_valid || bus.done) && w < 100) begin
            step();
            w++;
         end
         chk("timeout_len", 64'(w), 64'(T));
      end else begin
         repeat (rd[a]) step();
         bus.rx_valid = 1'b1;
         bus.rx_err   = re[a];
         bus.rx_data  = rp[a];
         bus.rx_pid   = pid_of(rk[a]);
         step();
         bus.rx_valid = 1'b0;
         bus.rx_err   = 1'b0;
      end
   endtask

   task automatic summary_fatal();
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "aborted");
   endtask

   task automatic run_txn(bit is_in, logic [3:0] endp,
                          logic [63:0] data, bit spur);
      int att = 0;
      int cyc = 0;
      bit fin = 0;
      bit rdy;
      bit held = 0;
      logic [3:0] hp = 4'h0;
      logic [63:0] hd = 64'h0;
      logic [3:0] lastpid = 4'h0;
      pkt_t e;
      model(is_in, endp, data);
      sig = 32'h0;
      chk("req_ready_idle", 64'(bus.req_ready), 64'h1);
      if (spur) begin
         bus.rx_valid = 1'b1;
         bus.rx_pid   = P_ACK;
         step();
         bus.rx_valid = 1'b0;
      end
      bus.req_valid = 1'b1;
      bus.req_is_in = is_in;
      bus.req_endp  = endp;
      bus.req_data  = data;
      step();
      bus.req_valid = 1'b0;
      bus.req_endp  = 4'($urandom);
      bus.req_data  = {$urandom, $urandom};
      while (!fin) begin
         if (cyc++ > 1500) begin
            $display("FAIL budget: got %0d cycles want done", cyc);
            bad++;
            summary_fatal();
         end
         if (bus.done) begin
            chk("exp_left", 64'(exp_q.size()), 64'h0);
            chk("success", 64'(bus.success), 64'(exp_ok));
            if (exp_ok && is_in) chk("rsp_data", bus.rsp_data, exp_rsp);
            chk("stat", 64'(bus.stat_retries), 64'(exp_stat()));
            last_ok  = bus.success;
            last_rsp = bus.rsp_data;
            step();
            chk("done_pulse", 64'(bus.done), 64'h0);
            fin = 1;
         end else if (bus.tx_valid) begin
            chk("ready_busy", 64'(bus.req_ready), 64'h0);
            if (held) begin
               chk("hold_pid", 64'(bus.tx_pid), 64'(hp));
               chk("hold_data", bus.tx_data, hd);
            end
            rdy = ($urandom_range(0, 2) != 0);
            bus.tx_ready = rdy;
            if (!rdy && spur && $urandom_range(0, 1) == 1) begin
               bus.rx_valid = 1'b1;
               bus.rx_pid   = pid_of(kind_e'($urandom_range(0, 5)));
               bus.rx_data  = {$urandom, $urandom};
            end
            if (rdy) begin
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL extra_pkt: got pid %h want none", bus.tx_pid);
               end else begin
                  e = exp_q.pop_front();
                  chk("tx_pid", 64'(bus.tx_pid), 64'(e.pid));
                  chk("tx_addr", 64'(bus.tx_addr), 64'(ADDR));
                  chk("tx_endp", 64'(bus.tx_endp), 64'(e.endp));
                  if (e.has_data) chk("tx_data", bus.tx_data, e.data);
               end
               sig = {sig[27:0], bus.tx_pid};
               lastpid = bus.tx_pid;
            end
            held = !rdy;
            hp = bus.tx_pid;
            hd = bus.tx_data;
            step();
            bus.tx_ready = 1'b0;
            bus.rx_valid = 1'b0;
            if (rdy && (lastpid == P_IN || lastpid == P_D0 || lastpid == P_D1))
               respond(att++);
         end else begin
            held = 0;
            step();
         end
      end
   endtask

   task automatic set_r(int a, kind_e k, int d, logic [63:0] p, bit er);
      rk[a] = k;
      rd[a] = d;
      rp[a] = p;
      re[a] = er;
   endtask

   task automatic clr_r();
      for (int i = 0; i < MR; i++) set_r(i, K_NONE, 0, 64'h0, 1'b0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want finish");
      bad++;
      summary_fatal();
   end

   initial begin
      bus.req_valid = 1'b0;
      bus.req_is_in = 1'b0;
      bus.req_endp  = 4'h0;
      bus.req_data  = 64'h0;
      bus.tx_ready  = 1'b0;
      bus.rx_valid  = 1'b0;
      bus.rx_pid    = 4'h0;
      bus.rx_data   = 64'h0;
      bus.rx_err    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_tx_valid", 64'(bus.tx_valid), 64'h0);
      chk("rst_done", 64'(bus.done), 64'h0);
      chk("rst_success", 64'(bus.success), 64'h0);
      chk("rst_rsp", bus.rsp_data, 64'h0);
      chk("rst_stat", 64'(bus.stat_retries), 64'h0);
      rst_L = 1'b1;
      step();
      chk("rst_ready", 64'(bus.req_ready), 64'h1);
      m_out = 0;
      m_in = 0;
      m_stat = 0;

      clr_r();
      set_r(0, K_ACK, 3, 64'h0, 1'b0);
      run_txn(1'b0, 4'd4, 64'hDEADBEEF_01234567, 1'b0);
      chk("sig_out1", 64'(sig), 64'h13);
      chk("ok_out1", 64'(last_ok), 64'h1);

      clr_r();
      set_r(0, K_ACK, T - 1, 64'h0, 1'b0);
      run_txn(1'b0, 4'd4, {$urandom, $urandom}, 1'b0);
      chk("sig_out2", 64'(sig), 64'h1B);
      chk("ok_collide", 64'(last_ok), 64'h1);

      clr_r();
      set_r(0, K_D0, 5, 64'hA5A5_0000_FFFF_1234, 1'b0);
      run_txn(1'b1, 4'd2, 64'h0, 1'b0);
      chk("sig_in", 64'(sig), 64'h92);
      chk("rsp_in", last_rsp, 64'hA5A5_0000_FFFF_1234);

      clr_r();
      set_r(0, K_NAK, 2, 64'h0, 1'b0);
      set_r(1, K_NAK, 1, 64'h0, 1'b0);
      set_r(2, K_ACK, 4, 64'h0, 1'b0);
      run_txn(1'b0, 4'd1, {$urandom, $urandom}, 1'b0);
      chk("sig_nak", 64'(sig), 64'h131313);
      chk("stat_nak", 64'(bus.stat_retries), 64'(STAT043));

      clr_r();
      run_txn(1'b1, 4'd3, 64'h0, 1'b0);
      chk("sig_tmo", 64'(sig), 64'h999);
      chk("ok_tmo", 64'(last_ok), 64'h0);

      bus.req_valid = 1'b1;
      bus.req_is_in = 1'b0;
      bus.req_endp  = 4'd4;
      bus.tx_ready  = 1'b1;
      step();
      bus.req_valid = 1'b0;
      chk("mid_tok", 64'(bus.tx_pid), 64'(P_OUT));
      step();
      chk("mid_data1", 64'(bus.tx_pid), 64'(P_D1));
      step();
      bus.tx_ready = 1'b0;
      step();
      rst_L = 1'b0;
      #1;
      chk("mid_rst_valid", 64'(bus.tx_valid), 64'h0);
      chk("mid_rst_done", 64'(bus.done), 64'h0);
      #3;
      rst_L = 1'b1;
      m_out = 0;
      m_in = 0;
      m_stat = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("no_done_rst", 64'(bus.done), 64'h0);
      end

      clr_r();
      set_r(0, K_D1, 2, 64'h1111_2222_3333_4444, 1'b0);
      set_r(1, K_D0, 1, 64'h0123_4567_89AB_CDEF, 1'b0);
      run_txn(1'b1, 4'd2, 64'h0, 1'b0);
      chk("sig_dup", 64'(sig), 64'h9292);
      chk("rsp_dup", last_rsp, 64'h0123_4567_89AB_CDEF);

      clr_r();
      set_r(0, K_ACK, 0, 64'h0, 1'b0);
      run_txn(1'b0, 4'd4, {$urandom, $urandom}, 1'b0);
      chk("sig_post_rst", 64'(sig), 64'h13);

      for (int n = 0; n < 40; n++) begin
         bit is_in;
         is_in = 1'($urandom);
         for (int a = 0; a < MR; a++) begin
            kind_e k;
            if ($urandom_range(0, 1) == 1)
               k = is_in ? kind_e'($urandom_range(4, 5)) : K_ACK;
            else
               k = kind_e'($urandom_range(0, 5));
            set_r(a, k, $urandom_range(0, T - 1),
                  {$urandom, $urandom}, ($urandom_range(0, 7) == 0));
         end
         run_txn(is_in, 4'($urandom), {$urandom, $urandom}, 1'b1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/usb_txn_engine.md
USB_TXN_ENGINE -- requirements
Module: usb_txn_engine

Interface
REQ-001 Parameter DATA_BYTES, default 8: payload bytes per DATA packet; legal range 1..64.
REQ-002 Parameter DEV_ADDR, default 7'h05: USB device address placed in every token.
REQ-003 Parameter TIMEOUT_CYC, default 255: maximum wait cycles for a response packet; legal range 2..65535.
REQ-004 Parameter MAX_RETRY, default 8: maximum transaction attempts before failure; legal range 1..255.
REQ-005 clk  in  1  sole clock; all state updates on posedge.
REQ-006 rst_L  in  1  asynchronous, active-low reset.
REQ-007 req_valid  in  1  request present.
REQ-008 req_ready  out  1  engine can accept a request.
REQ-009 req_is_in  in  1  1 = IN transaction, 0 = OUT transaction.
REQ-010 req_endp  in  4  target endpoint.
REQ-011 req_data  in  8*DATA_BYTES  OUT payload.
REQ-012 done  out  1  one-cycle completion pulse.
REQ-013 success  out  1  result of the completed transaction; valid while done=1.
REQ-014 rsp_data  out  8*DATA_BYTES  IN payload; valid while done=1 and success=1.
REQ-015 tx_valid / tx_ready  out / in  1 / 1  packet handoff to the encoder.
REQ-016 tx_pid  out  4  PID to send: OUT 0001, IN 1001, DATA0 0011, DATA1 1011, ACK 0010.
REQ-017 tx_addr / tx_endp / tx_data  out  7 / 4 / 8*DATA_BYTES  token and data fields.
REQ-018 rx_valid  in  1  one-cycle strobe for a decoded incoming packet.
REQ-019 rx_pid / rx_data / rx_err  in  4 / 8*DATA_BYTES / 1  received PID, payload, and CRC or bit-stuff error flag.
REQ-020 stat_retries  out  16  saturating count of retried attempts.

Function
REQ-021 States: IDLE, TOKEN, DATA, WAIT_HS, WAIT_DATA, ACK, FIN; req_ready=1 only in IDLE.
REQ-022 Request acceptance: req_valid&req_ready latches the request; TOKEN is entered and tx_valid is asserted on the next cycle.
REQ-023 Packet handoff: tx_valid and all tx_* fields hold stable until the cycle in which tx_valid&tx_ready; the state advances on that cycle.
REQ-024 OUT path: TOKEN(OUT) -> DATA(DATA0/1 per out_toggle) -> WAIT_HS.
REQ-025 IN path: TOKEN(IN) -> WAIT_DATA.
REQ-026 WAIT_HS: valid rx_pid=ACK with rx_err=0 -> out_toggle flips -> FIN with success=1.
REQ-027 WAIT_DATA: DATA PID equal to in_toggle with rx_err=0 -> rsp_data captured, in_toggle flips -> ACK state.
REQ-028 WAIT_DATA: DATA PID opposite in_toggle (duplicate) -> ACK sent, data discarded, toggle unchanged, attempt retried.
REQ-029 ACK state: sends ACK, then FIN with success=1.
REQ-030 Failed attempt: NAK, rx_err=1, unexpected PID, or timeout each count as one failed attempt.
REQ-031 Retry handling: attempt counter increments and the engine returns to TOKEN; when the attempt counter reaches MAX_RETRY, go to FIN with success=0.
REQ-032 Timeout counter: cleared on entry to a wait state, increments every cycle without rx_valid; timeout fires when it equals TIMEOUT_CYC-1.
REQ-033 Timeout/rx collision: rx_valid in the same cycle as timeout is processed; no timeout is taken.
REQ-034 rx_valid outside WAIT_HS/WAIT_DATA is ignored.
REQ-035 FIN: done=1 for exactly one cycle, then IDLE; a new request may be accepted on the following cycle.
REQ-036 stat_retries saturates at 16'hFFFF and does not wrap.

Reset
REQ-037 On rst_L=0 (asynchronous): state=IDLE, out_toggle=in_toggle=0 (DATA0), attempt and timeout counters=0, stat_retries=0.
REQ-038 On rst_L=0: tx_valid=0, done=0, success=0, rsp_data=0, req_ready=1 after release.
REQ-039 Reset mid-transaction abandons the transaction; no done pulse is produced.

Configuration
REQ-040 Macro USB_TXN_STATS_EN: when defined, stat_retries counts as specified; when undefined, stat_retries is tied to 0, no counter logic is instantiated, and all other behaviour is identical.

Verification
REQ-041 OUT endp 4, data 64'hDEADBEEF_01234567; device ACKs after 3 cycles -> tx sequence OUT, DATA0; done with success=1; the next OUT uses DATA1.
REQ-042 IN endp 2; device returns DATA0 64'hA5A5_0000_FFFF_1234 -> engine sends ACK; done, success=1, rsp_data matches.
REQ-043 OUT; device NAKs twice then ACKs -> 3 OUT tokens sent, success=1, stat_retries=2 (0 without USB_TXN_STATS_EN).
REQ-044 IN with no response, TIMEOUT_CYC=16, MAX_RETRY=3 -> 3 IN tokens, each wait exactly 16 cycles; done with success=0.
REQ-045 IN; device replies DATA1 while in_toggle=0 -> ACK sent, retry follows; DATA0 on retry -> success=1, rsp_data from the DATA0 packet.
REQ-046 rst_L pulsed low in WAIT_HS -> tx_valid=0 immediately, no done pulse, next OUT uses DATA0.
